// File: rtl/coproc_host_if.sv
`default_nettype none
// ============================================================================
// Module   : coproc_host_if
// Purpose  : Bridges a valid/ready host command/response channel to a
//            coprocessor driven by a 4-phase ENABLE / FLAG_DONE handshake,
//            with per-phase timeout and a synchronized FLAG_DONE input.
// Revision : 1.0 - initial release
// ============================================================================
module coproc_host_if #(
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // host command channel
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_op,
  input  logic [15:0] i_cmd_data,
  // host response channel
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_data,
  output logic [1:0]  o_rsp_status,
  // coprocessor side
  output logic [2:0]  o_instruction,
  output logic [15:0] o_data_to_cp,
  output logic        o_enable,
  input  logic [15:0] i_data_from_cp,
  input  logic        i_flag_done,
  // status
  output logic        o_busy
);

  localparam logic [19:0] c_TIMEOUT   = 20'(TIMEOUT_CYCLES);
  localparam logic [2:0]  c_OP_NOP    = 3'b000;
  localparam logic [2:0]  c_OP_ILLEGAL = 3'b111;
  localparam logic [1:0]  c_ST_OK      = 2'b00;
  localparam logic [1:0]  c_ST_TIMEOUT = 2'b01;
  localparam logic [1:0]  c_ST_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RELEASE   = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [19:0]            r_cnt;
  logic                   w_done_s;
  logic                   w_timeout;

  // Multi-flop synchronizer: FLAG_DONE may come from another clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_flag_done;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_done_s    = r_sync[SYNC_STAGES-1];
  assign w_timeout   = (r_cnt == c_TIMEOUT);
  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);

  // Handshake FSM with registered outputs and per-phase timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      o_enable      <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_status  <= c_ST_OK;
      o_instruction <= '0;
      o_data_to_cp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            o_instruction <= i_cmd_op;
            o_data_to_cp  <= i_cmd_data;
            if (i_cmd_op == c_OP_NOP || i_cmd_op == c_OP_ILLEGAL) begin
              // No coprocessor involvement: answer straight away.
              o_rsp_data   <= '0;
              o_rsp_status <= (i_cmd_op == c_OP_NOP) ? c_ST_OK : c_ST_ILLEGAL;
              o_rsp_valid  <= 1'b1;
              r_state      <= S_RESPOND;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          o_enable <= 1'b1;
          r_cnt    <= '0;
          r_state  <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          // Level-sensitive: a done flag already high counts as completion.
          if (w_done_s) begin
            o_rsp_data <= i_data_from_cp;
            o_enable   <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_RELEASE;
          end else if (w_timeout) begin
            o_enable     <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_status <= c_ST_TIMEOUT;
            o_rsp_valid  <= 1'b1;
            r_state      <= S_RESPOND;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end

        S_RELEASE: begin
          // Captured data is kept whether the flag drops or we time out.
          if (!w_done_s) begin
            o_rsp_status <= c_ST_OK;
            o_rsp_valid  <= 1'b1;
            r_state      <= S_RESPOND;
          end else if (w_timeout) begin
            o_rsp_status <= c_ST_TIMEOUT;
            o_rsp_valid  <= 1'b1;
            r_state      <= S_RESPOND;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end

        S_RESPOND: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          o_enable    <= 1'b0;
          o_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/coproc_host_if.md
COPROC_HOST_IF -- requirements
Module: coproc_host_if

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1048575; the maximum number of cycles to wait for each handshake phase before aborting.
REQ-002 Parameter: SYNC_STAGES, default 2; the number of synchronizer flops on flag_done.
REQ-003 clock  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request from the host software bridge.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_op  in  3  opcode: NOP=000, LOAD=001, STORE=010, ZOOM_IN_VP=011, ZOOM_IN_RP=100, ZOOM_OUT_MP=101, ZOOM_OUT_VD=110, 111 is illegal.
REQ-008 cmd_data  in  16  operand sent to the coprocessor.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-011 rsp_data  out  16  data word returned by the coprocessor.
REQ-012 rsp_status  out  2  00=OK, 01=TIMEOUT, 10=ILLEGAL.
REQ-013 instruction  out  3  drives the coprocessor INSTRUCTION input.
REQ-014 data_to_cp  out  16  drives the coprocessor DATA_IN input.
REQ-015 enable  out  1  drives the coprocessor ENABLE input.
REQ-016 data_from_cp  in  16  coprocessor DATA_OUT.
REQ-017 flag_done  in  1  coprocessor FLAG_DONE; may be asynchronous to clock.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The block SHALL pass flag_done through SYNC_STAGES flops before use; the synchronized value is done_s.
REQ-020 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT_DONE, RELEASE, RESPOND.
REQ-021 cmd_ready SHALL equal 1 only in IDLE, combinationally.
REQ-022 On IDLE accept, the block SHALL register cmd_op and cmd_data into instruction and data_to_cp, which stay stable until the next accept.
REQ-023 On accept of NOP or 111: no enable assertion; go directly to RESPOND next cycle; status OK for NOP, ILLEGAL for 111; rsp_data=0.
REQ-024 On accept of any other opcode: go to ISSUE; the cycle after, enable=1 and state=WAIT_DONE.
REQ-025 Handshake is 4-phase: enable held high until done_s=1 is sampled, then enable=0 in the next cycle.
REQ-026 WAIT_DONE with done_s=1: capture data_from_cp into rsp_data in the same edge, deassert enable, go to RELEASE.
REQ-027 RELEASE: wait for done_s=0, then go to RESPOND with status OK.
REQ-028 Timeout counter: 20-bit, cleared on entry to WAIT_DONE and to RELEASE, incremented each cycle in those states.
REQ-029 When the counter equals TIMEOUT_CYCLES in WAIT_DONE: enable=0, rsp_data=0, status TIMEOUT, go to RESPOND.
REQ-030 When the counter equals TIMEOUT_CYCLES in RELEASE: keep the captured rsp_data, status TIMEOUT, go to RESPOND.
REQ-031 RESPOND: rsp_valid=1; rsp_data and rsp_status are held stable until rsp_ready=1, then return to IDLE next cycle.
REQ-032 The best-case non-NOP latency SHALL be accept -> enable high 2 cycles, and done_s low -> rsp_valid 1 cycle.
REQ-033 done_s already high when WAIT_DONE is entered SHALL be treated as completion (no edge detection).
REQ-034 cmd_valid while busy SHALL be ignored; there is no command queueing.
REQ-035 The block SHALL never assert enable while rsp_valid=1.

Reset
REQ-036 Reset asserted, including mid-handshake: state=IDLE, enable=0, rsp_valid=0, rsp_data=0, rsp_status=00, instruction=000, data_to_cp=0, counter=0, and synchronizer flops=0.
REQ-037 After reset deasserts, the block SHALL accept a command in the first cycle that cmd_valid=1.

Verification
REQ-038 LOAD with cmd_data=0x1234; the model raises flag_done 5 cycles after enable and drives DATA_OUT=0xBEEF -> instruction=001, data_to_cp=0x1234, enable falls after done_s, rsp_data=0xBEEF, status 00.
REQ-039 NOP, then opcode 111 -> enable never rises; responses are status 00 then 10, rsp_data=0, each 1 cycle after accept.
REQ-040 ZOOM_IN_VP with flag_done stuck low and TIMEOUT_CYCLES=16 -> status 01, rsp_data=0, enable low after 16 WAIT_DONE cycles.
REQ-041 flag_done stuck high after completion, with TIMEOUT_CYCLES=16 -> status 01, rsp_data holds the captured value.
REQ-042 rsp_ready held low for 10 cycles, with cmd_valid pulsed meanwhile -> response stable, cmd_ready=0, no new enable.
REQ-043 reset asserted during WAIT_DONE -> enable=0 asynchronously and all outputs return to their reset values; the next LOAD completes normally.
